// File: rtl/eclk_bus_sequencer.sv
// eclk_bus_sequencer
// Sequences 6800-style peripheral accesses for two requesters against the
// ten-phase E-cycle supplied by the clock generator. A grant is taken at the
// phase-5 edge, the peripheral is selected for phases 6..9, and the winning
// requester receives a one-cycle ack in phase 0. Contention alternates
// between the two requesters.
//
// Ports:
//   clk                  system clock, all state on posedge
//   _reset               asynchronous active-low reset
//   eclk[9:0]            one-hot E-cycle phase
//   req0/req1            level requests, held until own ack
//   rw0/rw1              1 = read, 0 = write
//   addr0/addr1          peripheral register address
//   wdata0/wdata1        write data
//   ack0/ack1            one-cycle completion pulses
//   rdata                last read data, updated at read completion
//   e                    6800-style E clock (high in phases 6..9)
//   per_sel/per_rw       peripheral select / read-write
//   per_addr/per_wdata   peripheral address / write data
//   per_rdata            peripheral read data
//   busy                 access in progress (grant through ack)
module eclk_bus_sequencer (
    input  logic       clk,
    input  logic       _reset,
    input  logic [9:0] eclk,
    input  logic       req0,
    input  logic       req1,
    input  logic       rw0,
    input  logic       rw1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata,
    output logic       e,
    output logic       per_sel,
    output logic       per_rw,
    output logic [7:0] per_addr,
    output logic [7:0] per_wdata,
    input  logic [7:0] per_rdata,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic       grant_s;
    logic       done_s;
    logic       pick1_s;

    logic       gnt1_r;
    logic       last_r;
    logic       ack0_r;
    logic       ack1_r;
    logic [7:0] rdata_r;
    logic       e_r;
    logic       per_sel_r;
    logic       per_rw_r;
    logic [7:0] per_addr_r;
    logic [7:0] per_wdata_r;
    logic       busy_r;

    // Phases 0..4 carry no meaning for the sequencer; only 5..9 are used.
    logic       unused_eclk_s;
    assign unused_eclk_s = ^eclk[4:0];

    // Returns 1 when requester 1 wins. last_served = 1 means requester 1
    // was granted most recently, so requester 0 wins a tie.
    function automatic logic pick_req1(input logic r0, input logic r1,
                                       input logic last_served);
        logic p;
        if (r0 && r1) begin
            p = ~last_served;
        end else begin
            p = r1;
        end
        return p;
    endfunction

    assign ack0      = ack0_r;
    assign ack1      = ack1_r;
    assign rdata     = rdata_r;
    assign e         = e_r;
    assign per_sel   = per_sel_r;
    assign per_rw    = per_rw_r;
    assign per_addr  = per_addr_r;
    assign per_wdata = per_wdata_r;
    assign busy      = busy_r;

    // State register.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; grant_s / done_s strobe the datapath register updates.
    always_comb begin
        state_s = state_r;
        grant_s = 1'b0;
        done_s  = 1'b0;
        pick1_s = pick_req1(req0, req1, last_r);
        case (state_r)
            ST_IDLE: begin
                if (eclk[5] && (req0 || req1)) begin
                    state_s = ST_ACCESS;
                    grant_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // No timeout: a missing phase-9 strobe holds the access open.
                if (eclk[9]) begin
                    state_s = ST_ACK;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_ACCESS;
                end
            end
            ST_ACK: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Registered outputs, grant bookkeeping and read-data capture.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            gnt1_r      <= 1'b0;
            last_r      <= 1'b1;
            ack0_r      <= 1'b0;
            ack1_r      <= 1'b0;
            rdata_r     <= 8'h00;
            e_r         <= 1'b0;
            per_sel_r   <= 1'b0;
            per_rw_r    <= 1'b1;
            per_addr_r  <= 8'h00;
            per_wdata_r <= 8'h00;
            busy_r      <= 1'b0;
        end else begin
            e_r <= eclk[5] | eclk[6] | eclk[7] | eclk[8];
            if (grant_s) begin
                gnt1_r      <= pick1_s;
                last_r      <= pick1_s;
                per_rw_r    <= pick1_s ? rw1 : rw0;
                per_addr_r  <= pick1_s ? addr1 : addr0;
                per_wdata_r <= pick1_s ? wdata1 : wdata0;
                per_sel_r   <= 1'b1;
                busy_r      <= 1'b1;
            end else if (done_s) begin
                per_sel_r <= 1'b0;
                ack0_r    <= ~gnt1_r;
                ack1_r    <= gnt1_r;
                if (per_rw_r) begin
                    rdata_r <= per_rdata;
                end
            end else if (state_r == ST_ACK) begin
                ack0_r <= 1'b0;
                ack1_r <= 1'b0;
                busy_r <= 1'b0;
            end
        end
    end

endmodule
